stripe: RTL and testbench
=========================

STRIPE -- requirements
Module: stripe

Interface
REQ-001 Parameter DATA_W, default 32: width of input word and of each lane.
REQ-002 Parameter PAD_WORD, default 32'h0000_0000: filler word placed on lane1 by the pad feature.
REQ-003 clk_2f  input  1  the single clock, running at twice the lane rate; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk_2f.
REQ-005 dataIn  input  DATA_W  serial word stream.
REQ-006 validIn  input  1  dataIn is valid this cycle.
REQ-007 lane0  output  DATA_W  even-numbered word of the current pair, registered.
REQ-008 lane1  output  DATA_W  odd-numbered word of the current pair, registered.
REQ-009 valid0  output  1  lane0 holds a valid word, registered.
REQ-010 valid1  output  1  lane1 holds a valid word, registered.
REQ-011 pair_count  output  16  count of pairs emitted, including flushed pairs; wraps modulo 2^16.

Function
REQ-012 FSM states: IDLE (no staged word) and HALF (one even word staged).
- IDLE with validIn=1: stage dataIn and go to HALF.
- IDLE with validIn=0: stay in IDLE.
REQ-013 HALF with validIn=1 (pair completes): on that edge, lane0 takes the staged word and lane1 takes dataIn; valid0=valid1=1; go to IDLE.
REQ-014 HALF with validIn=0 (flush): on that edge, lane0 takes the staged word and valid0=1; lane1 is handled per REQ-023; go to IDLE.
REQ-015 Latency: lane1 is visible 1 cycle after its word is sampled; lane0 is visible 2 cycles after its word is sampled.
REQ-016 Hold: a 1-bit hold counter keeps lane0, lane1, valid0 and valid1 stable for exactly 2 cycles after each emission.
- If no new emission occurs, valid0 and valid1 clear at the end of those 2 cycles.
- lane0 and lane1 data retain their last value after valid clears.
REQ-017 Continuous validIn=1 emits one pair every 2 cycles, so valid0 and valid1 stay high with no gaps.
REQ-018 An emission that coincides with the last hold cycle takes priority: the new data loads and the hold counter restarts.
REQ-019 Word parity restarts at each return to IDLE: the first valid word after any gap or reset is always even (lane0).
REQ-020 pair_count increments by 1 on every emission, full or flushed; 16'hFFFF wraps to 16'h0000.

Reset
REQ-021 While reset=0 at a clock edge:
- state goes to IDLE and the staged word is discarded;
- lane0, lane1, valid0, valid1, pair_count and the hold counter all go to 0.
REQ-022 Reset asserted mid-pair or mid-hold takes priority over every other event; no flush occurs on the reset edge.

Configuration
REQ-023 Macro STRIPE_PAD_EN controls flush behaviour.
- Defined: on a flush, lane1 = PAD_WORD and valid1 = 1.
- Undefined: on a flush, lane1 keeps its previous value and valid1 = 0.

Structure
REQ-024 Shared package stripe_pkg holds:
- the FSM state encoding (IDLE, HALF);
- the DATA_W default;
- the pair_count width constant (16).
REQ-025 There is no sub-module; the stage register, FSM, hold counter and pair counter live in stripe.

Verification
REQ-026 Reset held low for 3 cycles then released with validIn=0 -> all outputs 0 and state IDLE.
REQ-027 Words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles ->
- lane0=0x11111111, lane1=0x22222222 visible 1 cycle after the 2nd word, held 2 cycles;
- then lane0=0x33333333, lane1=0x44444444;
- valid0 and valid1 high continuously for 4 cycles; pair_count=2.
REQ-028 Single word 0xAAAA5555 followed by validIn=0 ->
- lane0=0xAAAA5555, valid0=1;
- with STRIPE_PAD_EN: valid1=1 and lane1=PAD_WORD;
- without STRIPE_PAD_EN: valid1=0;
- both valids clear 2 cycles later; pair_count=1.
REQ-029 Word 0x01, a 1-cycle gap, then words 0x02 and 0x03 ->
- flush emits 0x01 on lane0;
- 0x02 goes to lane0 and 0x03 goes to lane1 (parity restarted).
REQ-030 reset=0 on the cycle after the even word 0x55 -> no emission of 0x55; all outputs 0.
REQ-031 pair_count preloaded to 0xFFFF by forcing, then one pair emitted -> pair_count=0x0000.

Source files
------------

// File: rtl/stripe_pkg.sv
// ============================================================================
// Module      : stripe_pkg
// Description : Shared constants and state encoding for the stripe block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stripe_pkg;

  localparam int c_DATA_W      = 32;
  localparam int c_PAIR_CNT_W  = 16;

  typedef logic [0:0] state_t;

  localparam state_t c_ST_IDLE = 1'b0;
  localparam state_t c_ST_HALF = 1'b1;

endpackage : stripe_pkg

`default_nettype wire

// File: rtl/stripe.sv
// ============================================================================
// Module      : stripe
// Description : Splits a serial word stream into two registered lanes
//               (even word on lane0, odd word on lane1) at half the rate.
// Config      : STRIPE_PAD_EN - flushed half-pairs carry PAD_WORD on lane1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stripe
  import stripe_pkg::*;
#(
  parameter int                DATA_W   = c_DATA_W,
  parameter logic [DATA_W-1:0] PAD_WORD = '0
) (
  input  logic                    clk_2f,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       dataIn,
  input  logic                    validIn,
  output logic [DATA_W-1:0]       lane0,
  output logic [DATA_W-1:0]       lane1,
  output logic                    valid0,
  output logic                    valid1,
  output logic [c_PAIR_CNT_W-1:0] pair_count
);

`ifdef STRIPE_PAD_EN
  localparam logic c_PAD_EN = 1'b1;
`else
  localparam logic c_PAD_EN = 1'b0;
`endif

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_W-1:0]       r_stage;
  logic [DATA_W-1:0]       r_lane0;
  logic [DATA_W-1:0]       r_lane1;
  logic                    r_valid0;
  logic                    r_valid1;
  logic                    r_hold;
  logic [c_PAIR_CNT_W-1:0] r_pair_count;

  logic                    w_stage_load;
  logic                    w_emit;
  logic                    w_full;
  logic [DATA_W-1:0]       w_lane1_nxt;
  logic                    w_valid1_nxt;

  // State register
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (validIn) w_state_nxt = c_ST_HALF;
      c_ST_HALF: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output decode: every HALF cycle emits, full pair or flush
  always_comb begin
    w_stage_load = 1'b0;
    w_emit       = 1'b0;
    w_full       = 1'b0;
    case (r_state)
      c_ST_IDLE: w_stage_load = validIn;
      c_ST_HALF: begin
        w_emit = 1'b1;
        w_full = validIn;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_lane1_nxt  = r_lane1;
    w_valid1_nxt = 1'b0;
    if (w_full) begin
      w_lane1_nxt  = dataIn;
      w_valid1_nxt = 1'b1;
    end else if (c_PAD_EN) begin
      w_lane1_nxt  = PAD_WORD;
      w_valid1_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_stage <= '0;
    end else if (w_stage_load) begin
      r_stage <= dataIn;
    end
  end

  // A new emission always wins over the hold countdown and restarts it
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_lane0      <= '0;
      r_lane1      <= '0;
      r_valid0     <= 1'b0;
      r_valid1     <= 1'b0;
      r_hold       <= 1'b0;
      r_pair_count <= '0;
    end else if (w_emit) begin
      r_lane0      <= r_stage;
      r_lane1      <= w_lane1_nxt;
      r_valid0     <= 1'b1;
      r_valid1     <= w_valid1_nxt;
      r_hold       <= 1'b0;
      r_pair_count <= r_pair_count + 1'b1;
    end else if (r_valid0 || r_valid1) begin
      if (r_hold) begin
        r_valid0 <= 1'b0;
        r_valid1 <= 1'b0;
        r_hold   <= 1'b0;
      end else begin
        r_hold   <= 1'b1;
      end
    end
  end

  assign lane0      = r_lane0;
  assign lane1      = r_lane1;
  assign valid0     = r_valid0;
  assign valid1     = r_valid1;
  assign pair_count = r_pair_count;

endmodule : stripe

`default_nettype wire

// File: tb/tb_stripe.sv
// ============================================================================
// Module      : tb_stripe
// Description : Directed self-checking bench for stripe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stripe;

  localparam int          c_W   = 32;
  localparam logic [31:0] c_PAD = 32'hDEAD_BEEF;

  logic          clk_2f;
  logic          reset;
  logic [c_W-1:0] dataIn;
  logic          validIn;
  logic [c_W-1:0] lane0;
  logic [c_W-1:0] lane1;
  logic          valid0;
  logic          valid1;
  logic [15:0]   pair_count;

  int checks   = 0;
  int failures = 0;
  logic [81:0] e;

  stripe #(.DATA_W(c_W), .PAD_WORD(c_PAD)) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .dataIn     (dataIn),
    .validIn    (validIn),
    .lane0      (lane0),
    .lane1      (lane1),
    .valid0     (valid0),
    .valid1     (valid1),
    .pair_count (pair_count)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  function automatic logic [81:0] obs();
    return {valid0, valid1, lane0, lane1, pair_count};
  endfunction

  task automatic step();
    @(posedge clk_2f);
    @(negedge clk_2f);
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    validIn = v;
    dataIn  = d;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(1'b0, 32'h0);
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF);
    repeat (3) step();
    e = '0;
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", obs(), e);
    end
    reset = 1'b1;
    drive(1'b0, 32'h0);
    step();
    checks++;
    if (obs() !== e || dut.r_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=%h state=%b exp=%h state=0", obs(), dut.r_state, e);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    drive(1'b1, 32'h1111_1111);
    step();
    e = '0;
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stream_first_word got=%h exp=%h", obs(), e);
    end
    drive(1'b1, 32'h2222_2222);
    step();
    e = {1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 16'd1};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stream_pair1 got=%h exp=%h", obs(), e);
    end
    drive(1'b1, 32'h3333_3333);
    step();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stream_pair1_hold got=%h exp=%h", obs(), e);
    end
    drive(1'b1, 32'h4444_4444);
    step();
    e = {1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444, 16'd2};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stream_pair2 got=%h exp=%h", obs(), e);
    end
    drive(1'b0, 32'h5555_5555);
    step();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stream_pair2_hold got=%h exp=%h", obs(), e);
    end
    step();
    e = {1'b0, 1'b0, 32'h3333_3333, 32'h4444_4444, 16'd2};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL stream_valid_clear got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    drive(1'b1, 32'hAAAA_5555);
    step();
    drive(1'b0, 32'h7777_7777);
    step();
`ifdef STRIPE_PAD_EN
    e = {1'b1, 1'b1, 32'hAAAA_5555, c_PAD, 16'd1};
`else
    e = {1'b1, 1'b0, 32'hAAAA_5555, 32'h0, 16'd1};
`endif
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL flush_emit got=%h exp=%h", obs(), e);
    end
    step();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL flush_hold got=%h exp=%h", obs(), e);
    end
    step();
    e[81:80] = 2'b00;
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL flush_clear got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_gap_parity();
    apply_reset();
    drive(1'b1, 32'h0000_0001);
    step();
    drive(1'b0, 32'h0000_0009);
    step();
    checks++;
    if ({valid0, lane0, pair_count} !== {1'b1, 32'h0000_0001, 16'd1}) begin
      failures++;
      $display("FAIL gap_flush got v0=%b l0=%h cnt=%h exp v0=1 l0=00000001 cnt=0001",
               valid0, lane0, pair_count);
    end
    drive(1'b1, 32'h0000_0002);
    step();
    drive(1'b1, 32'h0000_0003);
    step();
    e = {1'b1, 1'b1, 32'h0000_0002, 32'h0000_0003, 16'd2};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL gap_parity got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_reset_midpair();
    apply_reset();
    drive(1'b1, 32'h0000_0055);
    step();
    reset = 1'b0;
    drive(1'b1, 32'h0000_0066);
    step();
    e = '0;
    checks++;
    if (obs() !== e || dut.r_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_midpair got=%h state=%b exp=%h state=0", obs(), dut.r_state, e);
    end
    reset = 1'b1;
    drive(1'b0, 32'h0);
    step();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_midpair_after got=%h exp=%h", obs(), e);
    end
    drive(1'b1, 32'h0000_00A1);
    step();
    drive(1'b1, 32'h0000_00A2);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0);
    step();
    reset = 1'b1;
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_midhold got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    force dut.r_pair_count = 16'hFFFF;
    drive(1'b0, 32'h0);
    step();
    release dut.r_pair_count;
    drive(1'b1, 32'hC0DE_0001);
    step();
    drive(1'b1, 32'hC0DE_0002);
    step();
    e = {1'b1, 1'b1, 32'hC0DE_0001, 32'hC0DE_0002, 16'h0000};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL wrap_pair got=%h exp=%h", obs(), e);
    end
    drive(1'b1, 32'hC0DE_0003);
    step();
    drive(1'b1, 32'hC0DE_0004);
    step();
    checks++;
    if (pair_count !== 16'h0001) begin
      failures++;
      $display("FAIL wrap_next got=%h exp=0001", pair_count);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0);
    @(negedge clk_2f);
    test_reset();
    test_stream();
    test_flush();
    test_gap_parity();
    test_reset_midpair();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_stripe

`default_nettype wire
